// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: skews unskewed A-column/B-row wavefronts onto the
// west/north edges of an N x N systolic MAC array, drives the per-diagonal
// accumulator-clear (push) lines and pulses tile_done once every PE holds
// its final dot product.
// Optional build macro SYSTOLIC_FEEDER_FLUSH_EN: after the last beat of a
// tile the feeder stalls input for 2N-1 cycles so tiles never overlap.

// One skew lane: an input stage followed by DEPTH delay stages.
module systolic_feeder_lane #(
  parameter int DEPTH = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vld,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       nz
);

  logic [DEPTH:0][7:0] pipe;

  // Stage 0 captures the accepted operand (0 on a bubble); later stages delay it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= vld ? din : 8'h00;
      for (int s = 1; s <= DEPTH; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign dout = pipe[DEPTH];
  assign nz   = |pipe;

endmodule

module systolic_operand_feeder #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*N-1:0] a_in,
  input  logic [8*N-1:0] b_in,
  input  logic [KW-1:0]  k_len,
  output logic [8*N-1:0] a_out,
  output logic [8*N-1:0] b_out,
  output logic [2*N-2:0] push_out,
  output logic           tile_done,
  output logic           busy
);

  localparam int D = 2*N-1;  // number of anti-diagonals

`ifdef SYSTOLIC_FEEDER_FLUSH_EN
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  localparam state_t TILE_END = FLUSH;
`else
  typedef enum logic [1:0] {IDLE, STREAM} state_t;
  localparam state_t TILE_END = IDLE;
`endif

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d, cnt_q, cnt_d;
  logic          accept, beat0, last_beat;
  logic [D-1:0]  push_q;
  logic [D:0]    done_q;   // last-beat flag; bit D lands one cycle after PE(N-1,N-1) consumes it
  logic [N-1:0]  a_nz, b_nz;

  // Tile sequencing: beat counting, last-beat detection and input handshake.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    beat0     = 1'b0;
    last_beat = 1'b0;
    in_ready  = reset_n;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
    if (state_q == FLUSH) in_ready = 1'b0;
`endif
    accept = in_valid & in_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          beat0 = 1'b1;
          k_d   = (k_len == '0) ? KW'(1) : k_len;
          cnt_d = KW'(1);
          if (k_d > KW'(1)) begin
            state_d = STREAM;
          end else begin
            last_beat = 1'b1;
            state_d   = TILE_END;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + KW'(1);
          if (cnt_q == k_q - KW'(1)) begin
            last_beat = 1'b1;
            state_d   = TILE_END;
          end
        end
      end
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
      // Leave so that the cycle tile_done is high already accepts again.
      FLUSH: if (done_q[D-1]) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched tile depth and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // Push and done flags travel alongside the skewed data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_q <= '0;
      done_q <= '0;
    end else begin
      push_q <= {push_q[D-2:0], beat0};
      done_q <= {done_q[D-1:0], last_beat};
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_feeder_lane #(.DEPTH(i)) u_a (
      .clk(clk), .reset_n(reset_n), .vld(accept),
      .din(a_in[8*i +: 8]), .dout(a_out[8*i +: 8]), .nz(a_nz[i])
    );
    systolic_feeder_lane #(.DEPTH(i)) u_b (
      .clk(clk), .reset_n(reset_n), .vld(accept),
      .din(b_in[8*i +: 8]), .dout(b_out[8*i +: 8]), .nz(b_nz[i])
    );
  end

  assign push_out  = push_q;
  assign tile_done = done_q[D];
  assign busy      = (state_q != IDLE) | (|push_q) | (|done_q) | (|a_nz) | (|b_nz);

endmodule
